// File: rtl/rshp_wctrl_if.sv
// Input beat stream of the reshaper write controller.
// A beat moves on every rising clock edge where s_valid and s_ready are both high.
// s_valid must not wait for s_ready, and s_ready never depends on s_valid.
interface rshp_wctrl_if #(
    parameter int DW = 512
);
    localparam int BW = $clog2(DW/8) + 1;

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [BW-1:0] s_byte;

    modport master (
        output s_valid,
        output s_data,
        output s_byte,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_byte,
        output s_ready
    );
endinterface

// File: rtl/rshp_wctrl.sv
// Write-side controller of the reshaper byte FIFO. It admits a beat only when
// a full beat fits, counting the write still in flight, and stops after the job byte count.
module rshp_wctrl #(
    parameter int DW    = 512,
    parameter int BUFFW = 1536,
    parameter int LENW  = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           init_pulse,
    input  logic                           start,
    input  logic [LENW-1:0]                cfg_total_byte,
    rshp_wctrl_if.slave                    s,
    input  logic [$clog2(BUFFW/8):0]       ffvbyte,
    output logic                           ffwreq,
    output logic [$clog2(DW/8):0]          ffwbyte,
    output logic [DW-1:0]                  ffwdata,
    output logic                           busy,
    output logic                           done,
    output logic                           err_trunc,
    output logic [1:0]                     dbg_state
);
    localparam int NB  = DW / 8;
    localparam int BW  = $clog2(NB) + 1;
    localparam int FW  = $clog2(BUFFW/8) + 1;
    localparam int FRW = FW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [LENW-1:0]   r_remaining;
    logic              r_ffwreq;
    logic [BW-1:0]     r_ffwbyte;
    logic [DW-1:0]     r_ffwdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err_trunc;

    logic signed [FRW-1:0] w_free_raw;
    logic [FRW-1:0]        w_free;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_trunc;
    logic [BW-1:0]         w_wb;
    logic [LENW-1:0]       w_rem_next;
    logic [DW-1:0]         w_mdata;

    // Free space is pessimistic: the write issued last cycle is not yet in ffvbyte.
    always_comb begin
        w_free_raw = $signed(FRW'(BUFFW/8))
                   - $signed({1'b0, ffvbyte})
                   - $signed({{(FRW-BW){1'b0}}, (r_ffwreq ? r_ffwbyte : {BW{1'b0}})});
        w_free     = w_free_raw[FRW-1] ? {FRW{1'b0}} : w_free_raw;
    end

    assign w_ready  = (r_state == RUN) && (w_free >= FRW'(NB));
    assign w_accept = w_ready && s.s_valid;
    assign w_trunc  = LENW'(s.s_byte) > r_remaining;
    assign w_wb     = w_trunc ? r_remaining[BW-1:0] : s.s_byte;
    assign w_rem_next = r_remaining - LENW'(w_wb);

    always_comb begin
        w_mdata = '0;
        for (int i = 0; i < NB; i++) begin
            if (BW'(i) < w_wb) begin
                w_mdata[i*8 +: 8] = s.s_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_ffwreq    <= 1'b0;
            r_ffwbyte   <= '0;
            r_ffwdata   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_trunc <= 1'b0;
        end else if (init_pulse) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_ffwreq    <= 1'b0;
            r_ffwbyte   <= '0;
            r_ffwdata   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_trunc <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ffwreq  <= 1'b0;
                    r_ffwbyte <= '0;
                    r_ffwdata <= '0;
                    r_done    <= 1'b0;
                    if (start) begin
                        r_remaining <= cfg_total_byte;
                        r_err_trunc <= 1'b0;
                        if (cfg_total_byte == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_ffwreq    <= (w_wb != '0);
                        r_ffwbyte   <= w_wb;
                        r_ffwdata   <= w_mdata;
                        r_remaining <= w_rem_next;
                        if (w_trunc) begin
                            r_err_trunc <= 1'b1;
                        end
                        // The last write and done share a cycle.
                        if (w_rem_next == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_ffwreq  <= 1'b0;
                        r_ffwbyte <= '0;
                        r_ffwdata <= '0;
                    end
                end
                DONE: begin
                    r_done    <= 1'b0;
                    r_ffwreq  <= 1'b0;
                    r_ffwbyte <= '0;
                    r_ffwdata <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s.s_ready = w_ready;
    assign ffwreq    = r_ffwreq;
    assign ffwbyte   = r_ffwbyte;
    assign ffwdata   = r_ffwdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_trunc = r_err_trunc;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_rshp_wctrl.sv
// Directed bench for rshp_wctrl: reset, basic job with a FIFO occupancy model,
// backpressure, zero-length and zero-byte beats, init_pulse abort, start ignored in RUN.
module tb_rshp_wctrl;
    localparam int DW    = 512;
    localparam int BUFFW = 1536;
    localparam int LENW  = 32;
    localparam int BW    = $clog2(DW/8) + 1;
    localparam int FW    = $clog2(BUFFW/8) + 1;

    logic            clk;
    logic            reset_n;
    logic            init_pulse;
    logic            start;
    logic [LENW-1:0] cfg_total_byte;
    logic [FW-1:0]   ffvbyte;
    logic            ffwreq;
    logic [BW-1:0]   ffwbyte;
    logic [DW-1:0]   ffwdata;
    logic            busy;
    logic            done;
    logic            err_trunc;
    logic [1:0]      dbg_state;

    logic            model_en;
    logic            model_clr;
    logic [FW-1:0]   model_rd;
    logic [FW-1:0]   model_occ;
    logic [FW-1:0]   ffv_direct;

    int n_total;
    int n_pass;
    int n_fail;

    logic [DW-1:0] pat1, pat2, pat3, pat4, exp_d;

    rshp_wctrl_if #(.DW(DW)) s_if ();

    rshp_wctrl #(.DW(DW), .BUFFW(BUFFW), .LENW(LENW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .init_pulse     (init_pulse),
        .start          (start),
        .cfg_total_byte (cfg_total_byte),
        .s              (s_if.slave),
        .ffvbyte        (ffvbyte),
        .ffwreq         (ffwreq),
        .ffwbyte        (ffwbyte),
        .ffwdata        (ffwdata),
        .busy           (busy),
        .done           (done),
        .err_trunc      (err_trunc),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO occupancy reflects a write one cycle after the write cycle; no reads unless asked.
    always @(posedge clk) begin
        if (model_clr) model_occ <= '0;
        else model_occ <= model_occ + (ffwreq ? {{(FW-BW){1'b0}}, ffwbyte} : {FW{1'b0}}) - model_rd;
    end
    assign ffvbyte = model_en ? model_occ : ffv_direct;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_pat(input logic [7:0] seed);
        logic [DW-1:0] p;
        for (int i = 0; i < DW/8; i++) p[i*8 +: 8] = seed + 8'(i * 3);
        return p;
    endfunction

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        reset_n = 1'b0; init_pulse = 1'b0; start = 1'b0; cfg_total_byte = '0;
        s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_byte = '0;
        model_en = 1'b0; model_clr = 1'b1; model_rd = '0; ffv_direct = '0;
        pat1 = mk_pat(8'h11); pat2 = mk_pat(8'h42); pat3 = mk_pat(8'h73); pat4 = mk_pat(8'hA4);
        step(); step();
        reset_n = 1'b1;
        step();
        chk("reset_state", DW'(dbg_state), DW'(0));
        chk("reset_ready", DW'(s_if.s_ready), DW'(0));

        // Asynchronous reset in the middle of a job with s_valid high
        start = 1'b1; cfg_total_byte = 200;
        step();
        start = 1'b0;
        s_if.s_valid = 1'b1; s_if.s_byte = 64; s_if.s_data = pat1;
        step();
        chk("pre_rst_wreq", DW'(ffwreq), DW'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("arst_wreq", DW'(ffwreq), DW'(0));
        chk("arst_wbyte", DW'(ffwbyte), DW'(0));
        chk("arst_wdata", ffwdata, '0);
        chk("arst_busy", DW'(busy), DW'(0));
        chk("arst_ready", DW'(s_if.s_ready), DW'(0));
        #2 reset_n = 1'b1;
        step();
        chk("post_rst_ready", DW'(s_if.s_ready), DW'(0));
        chk("post_rst_state", DW'(dbg_state), DW'(0));
        s_if.s_valid = 1'b0;

        // Basic job with FIFO model: 200 bytes from four 64-byte beats
        model_en = 1'b1; model_clr = 1'b0;
        start = 1'b1; cfg_total_byte = 200;
        step();
        start = 1'b0;
        chk("b_busy", DW'(busy), DW'(1));
        chk("b_ready0", DW'(s_if.s_ready), DW'(1));
        s_if.s_valid = 1'b1; s_if.s_byte = 64; s_if.s_data = pat1;
        step();
        chk("b_w1_req", DW'(ffwreq), DW'(1));
        chk("b_w1_byte", DW'(ffwbyte), DW'(64));
        chk("b_w1_data", ffwdata, pat1);
        chk("b_ready1", DW'(s_if.s_ready), DW'(1));
        s_if.s_data = pat2;
        step();
        chk("b_w2_data", ffwdata, pat2);
        chk("b_ready2", DW'(s_if.s_ready), DW'(1));
        s_if.s_data = pat3;
        step();
        chk("b_w3_data", ffwdata, pat3);
        chk("b_w3_byte", DW'(ffwbyte), DW'(64));
        chk("b_ready3", DW'(s_if.s_ready), DW'(0));
        s_if.s_data = pat4;
        step();
        chk("b_stall_req", DW'(ffwreq), DW'(0));
        chk("b_stall_ready", DW'(s_if.s_ready), DW'(0));
        chk("b_occ_full", DW'(ffvbyte), DW'(192));
        model_rd = 64;
        step();
        model_rd = '0;
        chk("b_ready_after_rd", DW'(s_if.s_ready), DW'(1));
        step();
        exp_d = '0; exp_d[63:0] = pat4[63:0];
        chk("b_w4_req", DW'(ffwreq), DW'(1));
        chk("b_w4_byte", DW'(ffwbyte), DW'(8));
        chk("b_w4_data", ffwdata, exp_d);
        chk("b_done", DW'(done), DW'(1));
        chk("b_err", DW'(err_trunc), DW'(1));
        chk("b_busy_low", DW'(busy), DW'(0));
        s_if.s_valid = 1'b0;
        step();
        chk("b_done_pulse", DW'(done), DW'(0));
        chk("b_idle", DW'(dbg_state), DW'(0));
        chk("b_err_sticky", DW'(err_trunc), DW'(1));

        // Backpressure, then a zero-byte beat, then the exact final beat
        model_en = 1'b0; ffv_direct = 150;
        start = 1'b1; cfg_total_byte = 128;
        step();
        start = 1'b0;
        chk("bp_err_clr", DW'(err_trunc), DW'(0));
        chk("bp_ready150", DW'(s_if.s_ready), DW'(0));
        s_if.s_valid = 1'b1; s_if.s_byte = 64; s_if.s_data = pat2;
        step();
        chk("bp_no_write", DW'(ffwreq), DW'(0));
        ffv_direct = 128;
        #1;
        chk("bp_ready128", DW'(s_if.s_ready), DW'(1));
        step();
        chk("bp_wreq", DW'(ffwreq), DW'(1));
        chk("bp_wbyte", DW'(ffwbyte), DW'(64));
        chk("bp_ready_inflight", DW'(s_if.s_ready), DW'(0));
        s_if.s_valid = 1'b0; ffv_direct = 0;
        step();
        chk("z_ready", DW'(s_if.s_ready), DW'(1));
        s_if.s_valid = 1'b1; s_if.s_byte = 0;
        step();
        chk("z_no_write", DW'(ffwreq), DW'(0));
        chk("z_still_run", DW'(dbg_state), DW'(1));
        chk("z_busy", DW'(busy), DW'(1));
        s_if.s_byte = 64; s_if.s_data = pat3;
        step();
        chk("z_last_byte", DW'(ffwbyte), DW'(64));
        chk("z_last_done", DW'(done), DW'(1));
        chk("z_no_trunc", DW'(err_trunc), DW'(0));
        s_if.s_valid = 1'b0;
        step();

        // Zero-length job
        start = 1'b1; cfg_total_byte = 0;
        step();
        start = 1'b0;
        chk("t0_done", DW'(done), DW'(1));
        chk("t0_busy", DW'(busy), DW'(0));
        chk("t0_wreq", DW'(ffwreq), DW'(0));
        step();
        chk("t0_done_low", DW'(done), DW'(0));
        chk("t0_busy_low", DW'(busy), DW'(0));

        // init_pulse abort during a long job
        start = 1'b1; cfg_total_byte = 1000;
        step();
        start = 1'b0;
        s_if.s_valid = 1'b1; s_if.s_byte = 64; s_if.s_data = pat1;
        step(); step(); step();
        chk("ip_wreq_before", DW'(ffwreq), DW'(1));
        init_pulse = 1'b1;
        step();
        init_pulse = 1'b0;
        chk("ip_state", DW'(dbg_state), DW'(0));
        chk("ip_wreq", DW'(ffwreq), DW'(0));
        chk("ip_busy", DW'(busy), DW'(0));
        chk("ip_done", DW'(done), DW'(0));
        chk("ip_ready", DW'(s_if.s_ready), DW'(0));
        s_if.s_valid = 1'b0;
        start = 1'b1; cfg_total_byte = 64;
        step();
        start = 1'b0;
        s_if.s_valid = 1'b1; s_if.s_data = pat4;
        step();
        chk("ip2_wbyte", DW'(ffwbyte), DW'(64));
        chk("ip2_wdata", ffwdata, pat4);
        chk("ip2_done", DW'(done), DW'(1));
        s_if.s_valid = 1'b0;
        step();

        // A start while in RUN must not reload the length
        start = 1'b1; cfg_total_byte = 128;
        step();
        start = 1'b0;
        s_if.s_valid = 1'b1; s_if.s_byte = 64; s_if.s_data = pat2;
        step();
        chk("sr_w1_done", DW'(done), DW'(0));
        start = 1'b1; cfg_total_byte = 5;
        step();
        start = 1'b0;
        chk("sr_w2_byte", DW'(ffwbyte), DW'(64));
        chk("sr_w2_done", DW'(done), DW'(1));
        chk("sr_no_trunc", DW'(err_trunc), DW'(0));
        s_if.s_valid = 1'b0;
        step();
        chk("sr_idle", DW'(dbg_state), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rshp_wctrl.md
# rshp_wctrl

Write-side controller for the reshaper byte FIFO. It accepts a valid/ready stream of LSB-aligned, partially filled beats and issues byte-granular write requests to the FIFO. Each write is admitted only when the FIFO has room for a full beat, counting the write still in flight. For each job it enforces a programmed total byte count, truncating the final beat and signalling completion.

## Interface
- DW, 512, beat width in bits; also the FIFO write width
- BUFFW, 1536, FIFO capacity in bits
- LENW, 32, width of the job byte counter
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- init_pulse  in  1  synchronous abort/clear; also driven to the FIFO
- start  in  1  one-cycle pulse; loads cfg_total_byte and begins a job
- cfg_total_byte  in  LENW  bytes in the job; sampled on start
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  DW  beat data; byte 0 in bits [7:0]
- s_byte  in  $clog2(DW/8)+1  valid bytes in the beat, 0..DW/8
- ffvbyte  in  $clog2(BUFFW/8)+1  FIFO occupancy in bytes
- ffwreq  out  1  FIFO write request (registered)
- ffwbyte  out  $clog2(DW/8)+1  bytes written (registered)
- ffwdata  out  DW  write data; bytes at index ≥ ffwbyte are zero (registered)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at job end
- err_trunc  out  1  sticky; set when any beat was truncated; cleared by start/init_pulse

## Operation
- Reset / init_pulse:
  - state = IDLE
  - outputs ffwreq, ffwbyte, ffwdata, busy, done, err_trunc and s_ready = 0
  - remaining counter = 0
  - init_pulse has priority over everything else.
- States: IDLE, RUN, DONE.
  - IDLE: on start, remaining <= cfg_total_byte and err_trunc <= 0. If cfg_total_byte == 0 go to DONE, else go to RUN. s_ready = 0.
  - RUN: s_ready = (free ≥ DW/8). On accept:
    - wb = min(s_byte, remaining); remaining <= remaining − wb
    - ffwreq <= (wb != 0), ffwbyte <= wb, ffwdata <= s_data with bytes ≥ wb zeroed
    - if s_byte > remaining, set err_trunc
    - if remaining − wb == 0, go to DONE
    - If no beat is accepted, ffwreq <= 0.
  - DONE: done = 1 for exactly one cycle, s_ready = 0, ffwreq <= 0; next state is IDLE.
- free = BUFFW/8 − ffvbyte − (ffwreq ? ffwbyte : 0):
  - computed at $clog2(BUFFW/8)+2 bits, signed, clamped at 0
  - concurrent FIFO reads are ignored (conservative).
- start is ignored outside IDLE.
- A zero-byte beat in RUN is consumed: no write, remaining unchanged.
- s_ready depends only on registered state, ffvbyte and the output registers, never on s_valid.
- The controller never writes when the FIFO cannot hold a full beat, so no FIFO overflow is possible when ffvbyte is correct.

## Timing
- Accept at edge t: ffwreq/ffwbyte/ffwdata are valid in the cycle following edge t and held for one cycle only.
- The FIFO's ffvbyte reflects that write one cycle after the write cycle. The in-flight term in free covers that gap.
- Throughput: one beat per cycle while free ≥ DW/8 after each admitted write.
- The final accept moves the state to DONE at the same edge. done is high in the same cycle as the final ffwreq.
- busy falls with the entry to DONE; a new start is accepted one cycle after done.
- Total zero: done is high in the cycle after start, with no ffwreq.

## Test plan
All scenarios use DW=512, BUFFW=1536.
- Reset check: assert reset_n low mid-cycle with s_valid = 1 -> all outputs 0 asynchronously; s_ready stays 0 after release until start.
- Basic job: ffvbyte modelled by a FIFO model with no reads; start, total 200; four valid beats of 64 bytes ->
  - writes of 64, 64, 64 bytes; free is then 0 and s_ready = 0 until a model read frees space
  - after that read, the last write is 8 bytes, with bytes 8..63 of ffwdata zero
  - err_trunc = 1, done is coincident with the 8-byte write, and the fourth beat is consumed.
- Backpressure:
  - ffvbyte held at 150 -> s_ready = 0
  - ffvbyte dropped to 128 -> s_ready = 1; one beat of 64 accepted
  - next cycle: ffwreq = 1, ffwbyte = 64, ffvbyte still 128 -> free 0, s_ready = 0.
- Zero cases:
  - start with total 0 -> done pulse the next cycle, no ffwreq, busy never high
  - in RUN, an s_byte = 0 beat -> consumed, ffwreq = 0, remaining unchanged.
- init_pulse mid-job: total 1000, three beats written, then init_pulse with s_valid = 1 ->
  - next cycle state IDLE, all outputs 0, no done
  - a subsequent start with total 64 completes with a single 64-byte write.
- Start during RUN: second start with cfg_total_byte = 5 while in RUN -> ignored; the original job length completes.
